// File: rtl/profile_cache_counters.sv
// Cache profiling counters: per-channel access/hit/miss-run statistics with
// manual or periodic snapshots and a registered snapshot read port.
module profile_cache_counters #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned WINDOW = 0,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_hit,
  input  logic              clear,
  input  logic              snap_req,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [1:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              snap_done,
  output logic [NUM_CH-1:0] overflow
);

  localparam int unsigned WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned WIN_LAST = (WINDOW > 0) ? WINDOW - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] acc    [NUM_CH];
  logic [CNT_W-1:0] hits   [NUM_CH];
  logic [CNT_W-1:0] run    [NUM_CH];
  logic [CNT_W-1:0] maxrun [NUM_CH];
  logic [CNT_W-1:0] s_acc  [NUM_CH];
  logic [CNT_W-1:0] s_hits [NUM_CH];
  logic [CNT_W-1:0] s_max  [NUM_CH];

  logic [CNT_W-1:0] acc_c    [NUM_CH];
  logic [CNT_W-1:0] hits_c   [NUM_CH];
  logic [CNT_W-1:0] run_c    [NUM_CH];
  logic [CNT_W-1:0] maxrun_c [NUM_CH];
  logic [NUM_CH-1:0] sat_c;
  logic [WIN_W-1:0] win_cnt;
  logic auto_c;
  logic trig_c;
  logic [CNT_W-1:0] rd_mux_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Live counter values including this cycle's events, plus saturation flags
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      acc_c[i]    = acc[i];
      hits_c[i]   = hits[i];
      run_c[i]    = run[i];
      maxrun_c[i] = maxrun[i];
      sat_c[i]    = 1'b0;
      if (en && ch_valid[i]) begin
        acc_c[i] = sat_inc(acc[i]);
        sat_c[i] = (acc[i] == CNT_MAX);
        if (ch_hit[i]) begin
          hits_c[i] = sat_inc(hits[i]);
          run_c[i]  = '0;
          sat_c[i]  = sat_c[i] | (hits[i] == CNT_MAX);
        end else begin
          run_c[i] = sat_inc(run[i]);
          sat_c[i] = sat_c[i] | (run[i] == CNT_MAX);
          if (run_c[i] > maxrun[i]) maxrun_c[i] = run_c[i];
        end
      end
    end
  end

  // Snapshot trigger: manual request or end of an enabled-cycle window
  always_comb begin
    auto_c = (WINDOW != 0) && en && (win_cnt == WIN_W'(WIN_LAST));
    trig_c = snap_req | auto_c;
  end

  // Read mux over the committed snapshot; out-of-range channels read zero
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        case (rd_sel)
          2'd0:    rd_mux_c = s_acc[i];
          2'd1:    rd_mux_c = s_hits[i];
          2'd2:    rd_mux_c = s_max[i];
          default: rd_mux_c = (s_acc[i] >= s_hits[i]) ? s_acc[i] - s_hits[i] : '0;
        endcase
      end
    end
  end

  // Live counters, snapshot registers, window counter and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0; hits[i] <= '0; run[i] <= '0; maxrun[i] <= '0;
        s_acc[i] <= '0; s_hits[i] <= '0; s_max[i] <= '0;
      end
      win_cnt   <= '0;
      overflow  <= '0;
      snap_done <= 1'b0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0; hits[i] <= '0; run[i] <= '0; maxrun[i] <= '0;
        s_acc[i] <= '0; s_hits[i] <= '0; s_max[i] <= '0;
      end
      win_cnt   <= '0;
      overflow  <= '0;
      snap_done <= 1'b0;
    end else begin
      overflow  <= overflow | sat_c;
      snap_done <= trig_c;
      if (trig_c) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          s_acc[i] <= acc_c[i];
          s_hits[i] <= hits_c[i];
          s_max[i] <= maxrun_c[i];
          acc[i] <= '0; hits[i] <= '0; run[i] <= '0; maxrun[i] <= '0;
        end
        win_cnt <= '0;
      end else begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          acc[i]    <= acc_c[i];
          hits[i]   <= hits_c[i];
          run[i]    <= run_c[i];
          maxrun[i] <= maxrun_c[i];
        end
        if (en) win_cnt <= win_cnt + WIN_W'(1);
      end
    end
  end

  // Registered read port; data holds between reads and across clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (clear) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_profile_cache_counters.sv
// Scoreboard bench: two instances (4-bit manual-only, 8-bit with an 8-cycle
// window) share stimulus; a reference model queues expected outputs.
module tb_profile_cache_counters;

  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, clear = 1'b0, snap_req = 1'b0, rd_en = 1'b0;
  logic [NCH-1:0] ch_valid = '0, ch_hit = '0;
  logic [1:0] rd_ch = '0, rd_sel = '0;
  logic [3:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic rd_valid_a, rd_valid_b, snap_done_a, snap_done_b;
  logic [NCH-1:0] overflow_a, overflow_b;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  profile_cache_counters #(.NUM_CH(NCH), .CNT_W(4), .WINDOW(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .ch_valid(ch_valid), .ch_hit(ch_hit),
    .clear(clear), .snap_req(snap_req), .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .snap_done(snap_done_a), .overflow(overflow_a));

  profile_cache_counters #(.NUM_CH(NCH), .CNT_W(8), .WINDOW(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .ch_valid(ch_valid), .ch_hit(ch_hit),
    .clear(clear), .snap_req(snap_req), .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .snap_done(snap_done_b), .overflow(overflow_b));

  // Reference model state, per instance k and channel c
  typedef struct { int stamp; longint data; } rd_exp_t;
  longint lim [2] = '{15, 255};
  int     win_p [2] = '{0, 8};
  longint m_acc [2][NCH], m_hit [2][NCH], m_run [2][NCH], m_max [2][NCH];
  longint s_acc [2][NCH], s_hit [2][NCH], s_max [2][NCH];
  int     m_win [2];
  logic [NCH-1:0] m_ovf [2];
  rd_exp_t rd_q [2][$];
  int      snap_q [2][$];

  task automatic cmp(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d", nm, k, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[k][c] = 0; m_hit[k][c] = 0; m_run[k][c] = 0; m_max[k][c] = 0;
        s_acc[k][c] = 0; s_hit[k][c] = 0; s_max[k][c] = 0;
      end
      m_win[k] = 0;
      m_ovf[k] = '0;
      rd_q[k].delete();
      snap_q[k].delete();
    end
  endtask

  function automatic longint read_val(input int k, input int ch, input int sel);
    if (ch >= NCH) return 0;
    case (sel)
      0: return s_acc[k][ch];
      1: return s_hit[k][ch];
      2: return s_max[k][ch];
      default: return (s_acc[k][ch] > s_hit[k][ch]) ? s_acc[k][ch] - s_hit[k][ch] : 0;
    endcase
  endfunction

  // One clock of behaviour for instance k, from the inputs currently driven
  task automatic model(input int k);
    rd_exp_t it;
    longint mx;
    bit auto_t;
    mx = lim[k];
    if (rd_en && !clear) begin
      it.stamp = cyc + 1;
      it.data  = read_val(k, int'(rd_ch), int'(rd_sel));
      rd_q[k].push_back(it);
    end
    if (clear) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[k][c] = 0; m_hit[k][c] = 0; m_run[k][c] = 0; m_max[k][c] = 0;
        s_acc[k][c] = 0; s_hit[k][c] = 0; s_max[k][c] = 0;
      end
      m_win[k] = 0;
      m_ovf[k] = '0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      if (en && ch_valid[c]) begin
        if (m_acc[k][c] == mx) m_ovf[k][c] = 1'b1;
        m_acc[k][c] = (m_acc[k][c] + 1 > mx) ? mx : m_acc[k][c] + 1;
        if (ch_hit[c]) begin
          if (m_hit[k][c] == mx) m_ovf[k][c] = 1'b1;
          m_hit[k][c] = (m_hit[k][c] + 1 > mx) ? mx : m_hit[k][c] + 1;
          m_run[k][c] = 0;
        end else begin
          if (m_run[k][c] == mx) m_ovf[k][c] = 1'b1;
          m_run[k][c] = (m_run[k][c] + 1 > mx) ? mx : m_run[k][c] + 1;
          if (m_run[k][c] > m_max[k][c]) m_max[k][c] = m_run[k][c];
        end
      end
    end
    auto_t = (win_p[k] != 0) && en && (m_win[k] == win_p[k] - 1);
    if (en) m_win[k]++;
    if (snap_req || auto_t) begin
      for (int c = 0; c < NCH; c++) begin
        s_acc[k][c] = m_acc[k][c]; s_hit[k][c] = m_hit[k][c]; s_max[k][c] = m_max[k][c];
        m_acc[k][c] = 0; m_hit[k][c] = 0; m_run[k][c] = 0; m_max[k][c] = 0;
      end
      m_win[k] = 0;
      snap_q[k].push_back(cyc + 1);
    end
  endtask

  task automatic step(input logic e, input logic [NCH-1:0] v, input logic [NCH-1:0] h,
                      input logic clr, input logic sr, input logic re,
                      input logic [1:0] rc, input logic [1:0] rs);
    @(negedge clk);
    en = e; ch_valid = v; ch_hit = h; clear = clr; snap_req = sr;
    rd_en = re; rd_ch = rc; rd_sel = rs;
    for (int k = 0; k < 2; k++) model(k);
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_rd_data"}, 0, 64'(rd_data_a), 64'(0));
    cmp({tag, "_rd_data"}, 1, 64'(rd_data_b), 64'(0));
    cmp({tag, "_rd_valid"}, 0, 64'(rd_valid_a), 64'(0));
    cmp({tag, "_rd_valid"}, 1, 64'(rd_valid_b), 64'(0));
    cmp({tag, "_snap_done"}, 0, 64'(snap_done_a), 64'(0));
    cmp({tag, "_snap_done"}, 1, 64'(snap_done_b), 64'(0));
    cmp({tag, "_overflow"}, 0, 64'(overflow_a), 64'(0));
    cmp({tag, "_overflow"}, 1, 64'(overflow_b), 64'(0));
  endtask

  // Asynchronous reset asserted between clock edges, checked before the next edge
  task automatic mid_reset();
    @(negedge clk);
    en = 0; ch_valid = '0; ch_hit = '0; clear = 0; snap_req = 0; rd_en = 0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic read_all(input logic [1:0] ch);
    for (int s = 0; s < 4; s++) step(0, '0, '0, 0, 0, 1, ch, 2'(s));
  endtask

  // Monitor: pops the scoreboard whenever an output is due or presented
  task automatic check_dut(input int k);
    logic sd, rv;
    logic [NCH-1:0] ov;
    logic [63:0] d;
    bit exp_sd, exp_rv;
    longint exp_d;
    sd = (k == 0) ? snap_done_a : snap_done_b;
    rv = (k == 0) ? rd_valid_a : rd_valid_b;
    ov = (k == 0) ? overflow_a : overflow_b;
    d  = (k == 0) ? 64'(rd_data_a) : 64'(rd_data_b);
    exp_sd = (snap_q[k].size() > 0) && (snap_q[k][0] == cyc);
    if (exp_sd) void'(snap_q[k].pop_front());
    cmp("snap_done", k, 64'(sd), 64'(exp_sd));
    exp_rv = (rd_q[k].size() > 0) && (rd_q[k][0].stamp == cyc);
    exp_d = 0;
    if (exp_rv) begin
      exp_d = rd_q[k][0].data;
      void'(rd_q[k].pop_front());
    end
    cmp("rd_valid", k, 64'(rv), 64'(exp_rv));
    if (exp_rv && rv) cmp("rd_data", k, d, 64'(exp_d));
    cmp("overflow", k, 64'(ov), 64'(m_ovf[k]));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) for (int k = 0; k < 2; k++) check_dut(k);
    end
  end

  initial begin
    model_reset();
    #3 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ch0 H,M,M,M,H,M then a manual snapshot and read-back of every field
    step(1, 3'b001, 3'b001, 0, 0, 0, 0, 0);
    step(1, 3'b001, 3'b000, 0, 0, 0, 0, 0);
    step(1, 3'b001, 3'b000, 0, 0, 0, 0, 0);
    step(1, 3'b001, 3'b000, 0, 0, 0, 0, 0);
    step(1, 3'b001, 3'b001, 0, 0, 0, 0, 0);
    step(1, 3'b001, 3'b000, 0, 0, 0, 0, 0);
    step(1, 3'b000, 3'b000, 0, 1, 1, 0, 0);
    read_all(2'd0);

    // ch1 hit every cycle: periodic snapshots, stretched by 3 disabled cycles
    for (int i = 0; i < 40; i++)
      step((i >= 12 && i < 15) ? 1'b0 : 1'b1, 3'b010, 3'b010, 0, 0, 1, 2'd1, 2'(i % 2));

    // saturation on ch0, read-back, overflow persists until clear
    step(0, '0, '0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 3'b001, 3'b000, 0, 0, 1, 2'd0, 2'd0);
    step(1, 3'b000, 3'b000, 0, 1, 0, 0, 0);
    read_all(2'd0);
    repeat (3) step(0, '0, '0, 0, 0, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0, 0, 0);
    step(0, '0, '0, 0, 0, 0, 0, 0);

    // access on the snapshot cycle counts; an empty follow-up snapshot reads 0
    step(1, 3'b001, 3'b000, 0, 1, 0, 0, 0);
    read_all(2'd0);
    step(1, 3'b000, 3'b000, 0, 1, 0, 0, 0);
    read_all(2'd0);

    // clear beats a same-cycle snapshot and events; out-of-range channel reads 0
    step(1, 3'b011, 3'b000, 0, 1, 0, 0, 0);
    step(1, 3'b111, 3'b101, 1, 1, 0, 0, 0);
    read_all(2'd1);
    step(0, '0, '0, 0, 0, 1, 2'd3, 2'd0);
    step(0, '0, '0, 0, 0, 1, 2'd3, 2'd3);

    // reset mid-window after five accesses; only post-reset events survive
    for (int i = 0; i < 5; i++) step(1, 3'b001, 3'b001, 0, 0, (i == 4), 2'd1, 2'd0);
    mid_reset();
    step(1, 3'b001, 3'b001, 0, 0, 0, 0, 0);
    step(1, 3'b001, 3'b001, 0, 0, 0, 0, 0);
    step(1, 3'b000, 3'b000, 0, 1, 0, 0, 0);
    read_all(2'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic e, clr, sr, re;
      e   = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 63) == 0);
      sr  = ($urandom_range(0, 15) == 0);
      re  = clr ? 1'b0 : 1'($urandom_range(0, 1));
      step(e, 3'($urandom), 3'($urandom), clr, sr, re, 2'($urandom), 2'($urandom));
    end

    repeat (3) step(0, '0, '0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cmp("pending_reads", k, 64'(rd_q[k].size()), 64'(0));
      cmp("pending_snaps", k, 64'(snap_q[k].size()), 64'(0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
